// File: rtl/pipe_pkg.sv
// Shared register-scoreboard defaults and latency type for ID-stage hazard logic.
// Pure declarations: no latency, no flow control.
package pipe_pkg;

    localparam int DEF_REG_AW   = 5;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_MAX_LAT  = 7;
    localparam int DEF_LAT_W    = $clog2(DEF_MAX_LAT + 1);
    localparam int DEF_CNT_W    = 32;

    typedef logic [DEF_LAT_W-1:0] lat_t;

endpackage

// File: rtl/pipe_scoreboard_sb_entry.sv
// One scoreboard slot: bubbles remaining before the pending result can be forwarded.
// Updates every edge; clear beats load, load keeps the larger of decremented and new value.
// No backpressure: state always advances.
module sb_entry
    import pipe_pkg::*;
#(
    parameter int LAT_W = DEF_LAT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [LAT_W-1:0] lat_i,
    output logic [LAT_W-1:0] cnt_o
);

    logic [LAT_W-1:0] cnt_q;
    logic [LAT_W-1:0] cnt_d;
    logic [LAT_W-1:0] dec;

    always_comb begin
        dec   = (cnt_q != '0) ? (cnt_q - LAT_W'(1)) : '0;
        cnt_d = dec;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i && (lat_i > dec)) begin
            // An older, longer producer must never be hidden by a shorter one.
            cnt_d = lat_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_scoreboard.sv
// Per-register bubble scoreboard driving ID-stage stall, plus saturating stall counter.
// stall/issue_accept are combinational from current counters; counters move on each edge.
// Dependent ID instruction is held (stall) until every source it reads is forwardable.
module pipe_scoreboard
    import pipe_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int REG_AW   = DEF_REG_AW,
    parameter int MAX_LAT  = DEF_MAX_LAT,
    parameter int LAT_W    = $clog2(MAX_LAT + 1),
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue_valid,
    input  logic [REG_AW-1:0]   issue_rs,
    input  logic [REG_AW-1:0]   issue_rt,
    input  logic                issue_use_rs,
    input  logic                issue_use_rt,
    input  logic                issue_wr,
    input  logic [REG_AW-1:0]   issue_rd,
    input  logic [LAT_W-1:0]    issue_lat,
    input  logic                kill,
    output logic                stall,
    output logic                issue_accept,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [CNT_W-1:0]    stall_cycles
);

    logic             rs_hit;
    logic             rt_hit;
    logic             haz;
    logic             wr_en;
    logic [LAT_W-1:0] lat_eff;
    logic [CNT_W-1:0] stall_cycles_q;
    logic [CNT_W-1:0] stall_cycles_d;

    generate
        if (MAX_LAT >= (1 << LAT_W) - 1) begin : g_no_clamp
            assign lat_eff = issue_lat;
        end else begin : g_clamp
            localparam logic [LAT_W-1:0] MAX_V = LAT_W'(MAX_LAT);
            assign lat_eff = (issue_lat > MAX_V) ? MAX_V : issue_lat;
        end
    endgenerate

    // Only indices 1..NUM_REGS-1 can match, so r0 and out-of-range indices never hit.
    always_comb begin
        rs_hit = 1'b0;
        rt_hit = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if ((issue_rs == REG_AW'(r)) && busy_vec[r]) rs_hit = 1'b1;
            if ((issue_rt == REG_AW'(r)) && busy_vec[r]) rt_hit = 1'b1;
        end
    end

    assign haz          = (issue_use_rs && rs_hit) || (issue_use_rt && rt_hit);
    assign stall        = issue_valid && haz && !kill;
    assign issue_accept = issue_valid && !haz && !kill;
    assign wr_en        = issue_accept && issue_wr && (lat_eff != '0);

    assign busy_vec[0] = 1'b0;

    generate
        for (genvar r = 1; r < NUM_REGS; r++) begin : g_ent
            logic [LAT_W-1:0] cnt;
            logic             load;

            assign load = wr_en && (issue_rd == REG_AW'(r));

            sb_entry #(
                .LAT_W (LAT_W)
            ) u_entry (
                .clk    (clk),
                .rst_n  (rst_n),
                .clr_i  (kill),
                .load_i (load),
                .lat_i  (lat_eff),
                .cnt_o  (cnt)
            );

            assign busy_vec[r] = (cnt != '0);
        end
    endgenerate

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && !(&stall_cycles_q)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule
